// File: rtl/i2c_master_seq.sv
// Byte sequencer for the I2C master bit FSM: host write buffer, SCL divider with
// mid-phase strobes, bit/byte serving to the FSM, and completion/NACK reporting.
module i2c_master_seq #(
  parameter int CLK_DIV = 250,
  parameter int DEPTH   = 4,
  parameter int PTR_W   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  input  logic             go,
  output logic             busy,
  output logic             done,
  output logic             nack,
  output logic [PTR_W:0]   sent,
  output logic             start,
  output logic             scl_clk,
  output logic             cl_low,
  output logic             cl_high,
  output logic             msg_bit,
  output logic             last_bit,
  output logic             last_msg,
  input  logic             inc_bit,
  input  logic             inc_msg,
  input  logic             reading_sda,
  input  logic             sda_in,
  input  logic             fsm_idle
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_MID = DIV_W'(CLK_DIV / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARM        = 3'd1,
    ST_WAIT_LEAVE = 3'd2,
    ST_RUN        = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [7:0]         mem_r [DEPTH];
  logic [PTR_W:0]     count_r, count_s;
  logic [2:0]         bit_idx_r;
  logic [PTR_W-1:0]   msg_idx_r;
  logic [PTR_W:0]     sent_r;
  logic               nack_r, ack_pend_r, ack_sample_s, track_s;
  logic               wr_ready_r, busy_r, done_r, start_r;
  logic               div_en_r, div_en_s;
  logic [DIV_W-1:0]   div_cnt_r, div_cnt_s;
  logic               scl_r, scl_s, cl_low_r, cl_low_s, cl_high_r, cl_high_s;

  assign wr_ready = wr_ready_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign start    = start_r;
  assign nack     = nack_r;
  assign sent     = sent_r;
  assign scl_clk  = scl_r;
  assign cl_low   = cl_low_r;
  assign cl_high  = cl_high_r;

  assign msg_bit  = mem_r[msg_idx_r][3'd7 - bit_idx_r];
  assign last_bit = (bit_idx_r == 3'd7);
  assign last_msg = ({1'b0, msg_idx_r} == (count_r - (PTR_W+1)'(1)));

  assign track_s      = (state_r == ST_WAIT_LEAVE) || (state_r == ST_RUN);
  assign ack_sample_s = cl_high_r && reading_sda && ack_pend_r;

  // Controller next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (go && (count_r != (PTR_W+1)'(0))) state_s = ST_ARM;
        else                                  state_s = ST_IDLE;
      end
      ST_ARM:  state_s = ST_WAIT_LEAVE;
      ST_WAIT_LEAVE: begin
        if (!fsm_idle) state_s = ST_RUN;
        else           state_s = ST_WAIT_LEAVE;
      end
      ST_RUN: begin
        if (fsm_idle) state_s = ST_DONE;
        else          state_s = ST_RUN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Buffer fill level: grows on accepted writes, emptied when a transaction ends.
  always_comb begin
    count_s = count_r;
    case (state_r)
      ST_IDLE: begin
        if (wr_valid && wr_ready_r) count_s = count_r + (PTR_W+1)'(1);
        else                        count_s = count_r;
      end
      ST_DONE: count_s = (PTR_W+1)'(0);
      default: count_s = count_r;
    endcase
  end

  // SCL divider; a fresh enable always begins with a full high half-period.
  always_comb begin
    div_en_s  = div_en_r;
    div_cnt_s = DIV_W'(0);
    scl_s     = 1'b1;
    if (state_r == ST_ARM)       div_en_s = 1'b1;
    else if (state_r == ST_DONE) div_en_s = 1'b0;
    else                         div_en_s = div_en_r;
    if (div_en_s && div_en_r) begin
      if (div_cnt_r == DIV_MAX) begin
        div_cnt_s = DIV_W'(0);
        scl_s     = ~scl_r;
      end else begin
        div_cnt_s = div_cnt_r + DIV_W'(1);
        scl_s     = scl_r;
      end
    end else begin
      div_cnt_s = DIV_W'(0);
      scl_s     = 1'b1;
    end
    cl_high_s = div_en_s && (div_cnt_s == DIV_MID) && scl_s;
    cl_low_s  = div_en_s && (div_cnt_s == DIV_MID) && !scl_s;
  end

  // Controller state, host-facing flags and divider registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      count_r    <= (PTR_W+1)'(0);
      wr_ready_r <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      start_r    <= 1'b0;
      div_en_r   <= 1'b0;
      div_cnt_r  <= DIV_W'(0);
      scl_r      <= 1'b1;
      cl_low_r   <= 1'b0;
      cl_high_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      wr_ready_r <= (state_s == ST_IDLE) && (count_s < (PTR_W+1)'(DEPTH));
      busy_r     <= (state_s != ST_IDLE);
      done_r     <= (state_s == ST_DONE);
      start_r    <= (state_s == ST_ARM);
      div_en_r   <= div_en_s;
      div_cnt_r  <= div_cnt_s;
      scl_r      <= scl_s;
      cl_low_r   <= cl_low_s;
      cl_high_r  <= cl_high_s;
    end
  end

  // Byte storage; only entries below count are ever presented.
  always_ff @(posedge clock) begin
    if (wr_valid && wr_ready_r && !reset) mem_r[count_r[PTR_W-1:0]] <= wr_data;
  end

  // Bit/byte pointers and ACK bookkeeping driven by the FSM strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_idx_r  <= 3'd0;
      msg_idx_r  <= PTR_W'(0);
      sent_r     <= (PTR_W+1)'(0);
      nack_r     <= 1'b0;
      ack_pend_r <= 1'b0;
    end else if (state_r == ST_ARM) begin
      bit_idx_r  <= 3'd0;
      msg_idx_r  <= PTR_W'(0);
      sent_r     <= (PTR_W+1)'(0);
      nack_r     <= 1'b0;
      ack_pend_r <= 1'b0;
    end else begin
      if (track_s && inc_bit) bit_idx_r <= bit_idx_r + 3'd1;
      if (track_s && inc_msg) begin
        sent_r <= sent_r + (PTR_W+1)'(1);
        // Hold on the final byte so late strobes cannot step past the data.
        if ({1'b0, msg_idx_r} != (count_r - (PTR_W+1)'(1))) msg_idx_r <= msg_idx_r + PTR_W'(1);
      end
      if (track_s && inc_bit)  ack_pend_r <= 1'b1;
      else if (ack_sample_s)   ack_pend_r <= 1'b0;
      if (ack_sample_s && sda_in) nack_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_master_seq.sv
// Directed bench for i2c_master_seq with a small behavioural model of the bit FSM.
module tb_i2c_master_seq;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
  localparam int PTR_W   = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             wr_valid = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic             wr_ready;
  logic             go = 1'b0;
  logic             busy, done, nack, start, scl_clk, cl_low, cl_high;
  logic [PTR_W:0]   sent;
  logic             msg_bit, last_bit, last_msg;
  logic             inc_bit = 1'b0;
  logic             inc_msg = 1'b0;
  logic             reading_sda = 1'b0;
  logic             sda_in = 1'b0;
  logic             fsm_idle = 1'b1;

  logic [7:0]       bytes_v [4];
  int               n_tests = 0;
  int               n_fail = 0;

  i2c_master_seq #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .go(go), .busy(busy), .done(done), .nack(nack),
    .sent(sent), .start(start), .scl_clk(scl_clk), .cl_low(cl_low),
    .cl_high(cl_high), .msg_bit(msg_bit), .last_bit(last_bit),
    .last_msg(last_msg), .inc_bit(inc_bit), .inc_msg(inc_msg),
    .reading_sda(reading_sda), .sda_in(sda_in), .fsm_idle(fsm_idle)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_cl_low();
    int n = 0;
    do begin tick(); n++; end while (!cl_low && n < 64);
    check("wait_cl_low", 32'(cl_low), 32'd1);
  endtask

  task automatic wait_cl_high();
    int n = 0;
    do begin tick(); n++; end while (!cl_high && n < 64);
    check("wait_cl_high", 32'(cl_high), 32'd1);
  endtask

  task automatic pulse_go_expect_start();
    go = 1'b1;
    tick();
    go = 1'b0;
    check("start_pulse", 32'(start), 32'd1);
    check("busy_after_go", 32'(busy), 32'd1);
  endtask

  // Runs one transaction after start; nack_byte < 0 means every byte is ACKed.
  task automatic fsm_txn(input int nbytes, input int nack_byte, input int exp_sent);
    int n;
    int extra;
    fsm_idle = 1'b0;
    tick();
    for (int i = 0; i < nbytes; i++) begin
      for (int j = 0; j < 8; j++) begin
        wait_cl_low();
        check($sformatf("msg_bit_b%0d_%0d", i, j), 32'(msg_bit), 32'(bytes_v[i][7-j]));
        check($sformatf("last_bit_b%0d_%0d", i, j), 32'(last_bit), 32'(j == 7));
        check($sformatf("last_msg_b%0d_%0d", i, j), 32'(last_msg), 32'(i == nbytes - 1));
        inc_bit = 1'b1;
        tick();
        inc_bit = 1'b0;
      end
      wait_cl_low();
      reading_sda = 1'b1;
      sda_in = (i == nack_byte);
      wait_cl_high();
      tick();
      reading_sda = 1'b0;
      sda_in = 1'b0;
      if (i == nack_byte) break;
      inc_msg = 1'b1;
      tick();
      inc_msg = 1'b0;
    end
    wait_cl_low();
    check("last_msg_at_stop", 32'(last_msg), 32'(nack_byte < 0));
    fsm_idle = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!done && n < 16);
    check("done_pulse", 32'(done), 32'd1);
    check("nack", 32'(nack), 32'(nack_byte >= 0));
    check("sent", 32'(sent), 32'(exp_sent));
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_cleared", 32'(busy), 32'd0);
    check("wr_ready_after", 32'(wr_ready), 32'd1);
    check("scl_idle_high", 32'(scl_clk), 32'd1);
    check("count_cleared", 32'(last_msg), 32'd0);
    check("nack_held", 32'(nack), 32'(nack_byte >= 0));
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done || busy || cl_low || cl_high) extra++;
    end
    check("quiet_after_done", 32'(extra), 32'd0);
  endtask

  initial begin
    int bad;
    // Reset state
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_nack", 32'(nack), 32'd0);
    check("rst_sent", 32'(sent), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_scl", 32'(scl_clk), 32'd1);
    check("rst_cl_low", 32'(cl_low), 32'd0);
    check("rst_cl_high", 32'(cl_high), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    reset = 1'b0;
    tick();

    // Single byte 0xA5 with divider waveform check
    write_byte(8'hA5);
    check("wr_ready_1byte", 32'(wr_ready), 32'd1);
    check("last_msg_count1", 32'(last_msg), 32'd1);
    pulse_go_expect_start();
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) check("start_one_cycle", 32'(start), 32'd0);
      check($sformatf("scl_%0d", k), 32'(scl_clk), 32'((((k - 1) / 4) % 2) == 0));
      check($sformatf("cl_high_%0d", k), 32'(cl_high), 32'((((k - 1) % 4) == 1) && ((((k - 1) / 4) % 2) == 0)));
      check($sformatf("cl_low_%0d", k), 32'(cl_low), 32'((((k - 1) % 4) == 1) && ((((k - 1) / 4) % 2) == 1)));
    end
    bytes_v[0] = 8'hA5;
    fsm_txn(1, -1, 1);

    // go with an empty buffer is ignored
    go = 1'b1;
    tick();
    go = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      if (start || busy || done) bad++;
      tick();
    end
    check("go_empty_ignored", 32'(bad), 32'd0);

    // Fill buffer, fifth write dropped, poke go/wr_valid while busy
    write_byte(8'h12);
    write_byte(8'h34);
    write_byte(8'h56);
    check("wr_ready_3", 32'(wr_ready), 32'd1);
    write_byte(8'h78);
    check("wr_ready_full", 32'(wr_ready), 32'd0);
    write_byte(8'h9A);
    check("wr_ready_still_full", 32'(wr_ready), 32'd0);
    pulse_go_expect_start();
    go = 1'b1;
    wr_valid = 1'b1;
    wr_data = 8'hFF;
    tick();
    go = 1'b0;
    wr_valid = 1'b0;
    check("wr_ready_busy", 32'(wr_ready), 32'd0);
    tick();
    check("no_restart_busy", 32'(start), 32'd0);
    bytes_v[0] = 8'h12;
    bytes_v[1] = 8'h34;
    bytes_v[2] = 8'h56;
    bytes_v[3] = 8'h78;
    fsm_txn(4, -1, 4);

    // NACK on the first byte stops before 0x34
    write_byte(8'h12);
    write_byte(8'h34);
    pulse_go_expect_start();
    bytes_v[0] = 8'h12;
    bytes_v[1] = 8'h34;
    fsm_txn(2, 0, 0);

    // Reset during the third bit
    write_byte(8'h5A);
    pulse_go_expect_start();
    fsm_idle = 1'b0;
    tick();
    for (int j = 0; j < 2; j++) begin
      wait_cl_low();
      inc_bit = 1'b1;
      tick();
      inc_bit = 1'b0;
    end
    wait_cl_low();
    check("third_bit", 32'(msg_bit), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fsm_idle = 1'b1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_scl", 32'(scl_clk), 32'd1);
    check("mid_rst_cl_low", 32'(cl_low), 32'd0);
    check("mid_rst_cl_high", 32'(cl_high), 32'd0);
    check("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
    check("mid_rst_count", 32'(last_msg), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done || busy || !scl_clk) bad++;
    end
    check("mid_rst_quiet", 32'(bad), 32'd0);

    // Normal operation resumes after reset
    write_byte(8'h3C);
    pulse_go_expect_start();
    bytes_v[0] = 8'h3C;
    fsm_txn(1, -1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_master_seq.md
Name: i2c_master_seq

Overview:
- Upstream companion to the I2C master bit-level FSM.
- Accepts bytes from a host into a small write buffer.
- Generates the divided SCL waveform and its mid-phase strobes (scl_clk, cl_low, cl_high).
- Serves msg_bit, last_bit and last_msg to the FSM, advances on its inc_bit/inc_msg, issues the start pulse, and reports completion and NACK status back to the host.

Parameters:
CLK_DIV, 250, system clocks per SCL half-period (even, >=4)
DEPTH, 4, message buffer entries (bytes, power of 2)
PTR_W, 2, log2(DEPTH)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
wr_valid  in  1  host byte write strobe
wr_data  in  8  host byte, transmitted MSB first
wr_ready  out  1  buffer accepts write
go  in  1  one-cycle request to transmit buffered bytes
busy  out  1  transaction in progress
done  out  1  one-cycle pulse at transaction end
nack  out  1  last transaction ended on NACK (valid from done until next go)
sent  out  PTR_W+1  bytes ACKed in last transaction
start  out  1  to FSM start
scl_clk  out  1  divided SCL, to FSM scl_in
cl_low  out  1  one-cycle strobe, middle of SCL low phase
cl_high  out  1  one-cycle strobe, middle of SCL high phase
msg_bit  out  1  current bit to FSM
last_bit  out  1  current bit is bit 0 of byte (8th sent)
last_msg  out  1  current byte is final buffered byte
inc_bit  in  1  from FSM
inc_msg  in  1  from FSM
reading_sda  in  1  from FSM
sda_in  in  1  sampled SDA line
fsm_idle  in  1  FSM idle

Behaviour:
- Reset values:
  - Outputs: busy=0, done=0, nack=0, sent=0, start=0, scl_clk=1, cl_low=0, cl_high=0.
  - Internal state: count=0, bit_idx=0, msg_idx=0, wr_ready=1.
  - Controller returns to IDLE from any state.
- Buffer:
  - wr_ready = (ctl==IDLE) && count<DEPTH.
  - A write when wr_valid && wr_ready stores wr_data at mem[count] and increments count.
  - A write when wr_ready=0 is dropped.
- Controller states:
  - IDLE: go && count>0 -> ARM. go with count==0 is ignored.
  - ARM (1 cycle): start=1. Clear bit_idx, msg_idx, nack, sent. Enable divider. -> WAIT_LEAVE.
  - WAIT_LEAVE: fsm_idle==0 -> RUN.
  - RUN: fsm_idle==1 -> DONE.
  - DONE (1 cycle): done=1. Clear count. Disable divider. -> IDLE.
- busy = (ctl != IDLE). go while busy is ignored.
- Divider:
  - Disabled: div_cnt=0, scl_clk=1, no strobes.
  - Enabled: div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0 and scl_clk toggles. The first half-period after enable is high.
  - cl_high=1 when div_cnt==CLK_DIV/2-1 && scl_clk==1.
  - cl_low=1 when div_cnt==CLK_DIV/2-1 && scl_clk==0.
  - Strobes are exactly one cycle, one per half-period.
- Data path (combinational):
  - msg_bit = mem[msg_idx][7-bit_idx]
  - last_bit = (bit_idx==7)
  - last_msg = (msg_idx==count-1)
- Counter updates:
  - inc_bit: bit_idx <= bit_idx+1, wrapping 7->0. It also sets ack_pend.
  - inc_msg: msg_idx <= msg_idx+1 and sent <= sent+1. msg_idx saturates at count-1; sent has no saturation.
  - Both inputs are sampled only in RUN/WAIT_LEAVE and ignored otherwise.
- ACK capture:
  - On cl_high && reading_sda && ack_pend, clear ack_pend.
  - If sda_in==1 at that sample, set nack=1.
  - nack holds until the next ARM.
- Timing: outputs reflecting inc_bit/inc_msg change the cycle after the FSM strobe. The FSM samples last_bit/last_msg in the same cycle it raises inc_*, so the pre-increment values apply.
- Reset mid-transaction: divider stops, scl_clk=1, buffer contents are discarded (count=0), and no done pulse is issued.

Test Plan:
- CLK_DIV=4, reset; write 0xA5 -> count=1, wr_ready=1.
  - go -> start high 1 cycle, busy=1.
  - scl_clk period 8 cycles, starting high.
  - cl_high at div_cnt 1 of high phase; cl_low at div_cnt 1 of low phase.
- Byte 0xA5, FSM model ACKs (sda_in=0) -> msg_bit sequence 1,0,1,0,0,1,0,1; last_bit only during the 8th bit.
  - done pulse when fsm_idle returns; nack=0, sent=1, count=0.
- Write 4 bytes 0x12,0x34,0x56,0x78 -> wr_ready drops after the 4th; a 5th write is dropped.
  - All ACKed -> last_msg only on 0x78; sent=4.
- Bytes 0x12,0x34 with sda_in=1 at the first ACK cl_high -> nack=1, sent=0, done pulse, and 0x34 is never presented.
- go with count=0, or go and wr_valid while busy -> no start, buffer unchanged, no extra done.
- Reset asserted during the 3rd bit -> next cycle: busy=0, scl_clk=1, strobes 0, wr_ready=1, count=0, no done.
